// File: rtl/mb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mb_sched_pkg
//  Description : Shared types and constants for the intra mode-decision
//                frame scheduler (state encoding, default widths/depths).
//  Revision    : 1.0 - initial release
// ============================================================================
package mb_sched_pkg;

    // Default MB coordinate / frame dimension width
    localparam int MB_COORD_W   = 10;
    // Default number of output-buffer slots (credit counter reset value)
    localparam int MB_OUT_DEPTH = 4;

    // One-hot scheduler state encoding
    localparam int                STATE_W   = 6;
    localparam logic [STATE_W-1:0] ST_IDLE   = 6'b000001;
    localparam logic [STATE_W-1:0] ST_LOAD   = 6'b000010;
    localparam logic [STATE_W-1:0] ST_LAUNCH = 6'b000100;
    localparam logic [STATE_W-1:0] ST_RUN    = 6'b001000;
    localparam logic [STATE_W-1:0] ST_COMMIT = 6'b010000;
    localparam logic [STATE_W-1:0] ST_DONE   = 6'b100000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_LAUNCH = ST_LAUNCH,
        S_RUN    = ST_RUN,
        S_COMMIT = ST_COMMIT,
        S_DONE   = ST_DONE
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sched_credit_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : sched_credit_ctr
//  Description : Saturating up/down counter of free output-buffer slots.
//                Resets full; a return coincident with a consume is a no-op;
//                a return while full saturates and flags overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_credit_ctr
    import mb_sched_pkg::*;
#(
    parameter int DEPTH = MB_OUT_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic consume,
    input  logic ret,
    output logic credits_avail,
    output logic overflow
);

    localparam int                c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_empty;

    assign w_full        = (r_count == c_full);
    assign w_empty       = (r_count == '0);
    assign credits_avail = !w_empty;
    // A lone return against a full counter has nowhere to go
    assign overflow      = ret && !consume && w_full;

    // Count up on a lone return, down on a lone consume, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_full;
        end else if (ret && !consume && !w_full) begin
            r_count <= r_count + c_one;
        end else if (consume && !ret && !w_empty) begin
            r_count <= r_count - c_one;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mb_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mb_mode_scheduler
//  Description : Frame-level sequencer for intra mode decision. Walks MBs in
//                raster order, launches the luma and UV pickers together,
//                waits for both completions and commits each MB, gated by
//                neighbour-context readiness and output-buffer credits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mb_mode_scheduler
    import mb_sched_pkg::*;
#(
    parameter int OUT_DEPTH = MB_OUT_DEPTH,
    parameter int COORD_W   = MB_COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] mb_w,
    input  logic [COORD_W-1:0] mb_h,
    input  logic               ctx_ready,
    output logic               luma_start,
    input  logic               luma_done,
    output logic               uv_start,
    input  logic               uv_done,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               left_avail,
    output logic               top_avail,
    output logic               commit,
    input  logic               credit_ret,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);

    localparam logic [COORD_W-1:0] c_coord_one = COORD_W'(1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_mb_w;
    logic [COORD_W-1:0] r_mb_h;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic [COORD_W-1:0] w_mb_w_nxt;
    logic [COORD_W-1:0] w_mb_h_nxt;

    logic r_luma_got;
    logic r_uv_got;
    logic w_luma_got_nxt;
    logic w_uv_got_nxt;
    logic r_busy;
    logic w_busy_nxt;
    logic r_err;
    logic w_err_nxt;

    logic r_luma_start;
    logic r_uv_start;
    logic r_commit;
    logic r_frame_done;
    logic r_left_avail;
    logic r_top_avail;

    logic w_consume;
    logic w_credits_avail;
    logic w_overflow;
    logic w_dims_ok;
    logic w_last_col;
    logic w_last_row;

    assign w_dims_ok  = (mb_w != '0) && (mb_h != '0);
    assign w_last_col = (r_x == (r_mb_w - c_coord_one));
    assign w_last_row = (r_y == (r_mb_h - c_coord_one));

    assign luma_start = r_luma_start;
    assign uv_start   = r_uv_start;
    assign commit     = r_commit;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign err        = r_err;
    assign x_o        = r_x;
    assign y_o        = r_y;
    assign left_avail = r_left_avail;
    assign top_avail  = r_top_avail;

    sched_credit_ctr #(
        .DEPTH (OUT_DEPTH)
    ) u_credit (
        .clk           (clk),
        .rst_n         (rst_n),
        .consume       (w_consume),
        .ret           (credit_ret),
        .credits_avail (w_credits_avail),
        .overflow      (w_overflow)
    );

    // Next-state, coordinate walk and sticky error decode
    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_mb_w_nxt     = r_mb_w;
        w_mb_h_nxt     = r_mb_h;
        w_luma_got_nxt = r_luma_got;
        w_uv_got_nxt   = r_uv_got;
        w_busy_nxt     = r_busy;
        w_err_nxt      = r_err;
        w_consume      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    if (w_dims_ok) begin
                        w_mb_w_nxt  = mb_w;
                        w_mb_h_nxt  = mb_h;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_err_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        // Empty frame: report completion without launching
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (ctx_ready && w_credits_avail) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_luma_got_nxt = 1'b0;
                w_uv_got_nxt   = 1'b0;
                w_state_nxt    = S_RUN;
            end
            S_RUN: begin
                if (luma_done) begin
                    w_luma_got_nxt = 1'b1;
                end
                if (uv_done) begin
                    w_uv_got_nxt = 1'b1;
                end
                // Completions may arrive in either order or together
                if ((r_luma_got || luma_done) && (r_uv_got || uv_done)) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_consume = 1'b1;
                if (w_last_col && w_last_row) begin
                    // Last MB keeps its coordinates visible after the frame
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                    if (w_last_col) begin
                        w_x_nxt = '0;
                        w_y_nxt = r_y + c_coord_one;
                    end else begin
                        w_x_nxt = r_x + c_coord_one;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Protocol errors are sticky and take precedence over the clear
        if (r_state == S_RUN) begin
            if ((luma_done && r_luma_got) || (uv_done && r_uv_got)) begin
                w_err_nxt = 1'b1;
            end
        end else if (luma_done || uv_done) begin
            w_err_nxt = 1'b1;
        end
        if (w_overflow) begin
            w_err_nxt = 1'b1;
        end
    end

    // State, context and registered output pulses derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_mb_w       <= '0;
            r_mb_h       <= '0;
            r_luma_got   <= 1'b0;
            r_uv_got     <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_luma_start <= 1'b0;
            r_uv_start   <= 1'b0;
            r_commit     <= 1'b0;
            r_frame_done <= 1'b0;
            r_left_avail <= 1'b0;
            r_top_avail  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_mb_w       <= w_mb_w_nxt;
            r_mb_h       <= w_mb_h_nxt;
            r_luma_got   <= w_luma_got_nxt;
            r_uv_got     <= w_uv_got_nxt;
            r_busy       <= w_busy_nxt;
            r_err        <= w_err_nxt;
            r_luma_start <= (w_state_nxt == S_LAUNCH);
            r_uv_start   <= (w_state_nxt == S_LAUNCH);
            r_commit     <= (w_state_nxt == S_COMMIT);
            r_frame_done <= (w_state_nxt == S_DONE);
            r_left_avail <= (w_x_nxt != '0);
            r_top_avail  <= (w_y_nxt != '0);
        end
    end

endmodule
`default_nettype wire
